aes_dr_cipher_collector: RTL and testbench
==========================================

Name: aes_dr_cipher_collector

Overview:
- Sits directly downstream of the dual-rail AES-256 core and consumes its Cipher_text_T/Cipher_text_F rails and its Done strobe.
- Waits through precharge spacers, checks dual-rail codeword validity, and latches the 128-bit ciphertext into a single-rail register.
- Streams the result to the host as four 32-bit words over a valid/ready handshake.
- Flags spacer timeouts, invalid (1,1) codewords and overruns.

Parameters:
- N, 128, ciphertext width; fixed at 128, four output words.
- W, 32, output word width.
- TIMEOUT_CYC, 16, maximum cycles in ARMED before a valid codeword is seen; legal range 2..255.
- CAPTURE_DLY, 2, fixed capture delay after the Done edge; used only when AES_DR_FAULT_CHECK_EN is undefined.

Ports:
- Clk  in  1  system clock, all flops on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Cipher_text_T  in  N  true rail from the core.
- Cipher_text_F  in  N  false rail from the core.
- Done  in  1  core completion strobe.
- Out_Data  out  W  current output word.
- Out_Valid  out  1  Out_Data is valid.
- Out_Ready  in  1  host accepts the word.
- Out_Last  out  1  high with the fourth word.
- Busy  out  1  high in any state other than IDLE.
- Fault  out  1  sticky fault indication.
- Fault_Code  out  2  cause: 0 none, 1 timeout, 2 invalid (1,1) pair, 3 overrun.
- Fault_Clr  in  1  single-cycle pulse; clears the fault and returns to IDLE.

Behaviour:
- Reset (Reset=0): all outputs 0; internal flops 0; state IDLE. The effect is immediate and asynchronous, including mid-stream. Any partial transfer is abandoned.
- Edge detect: Done_d is a registered copy of Done. done_rise = Done & ~Done_d. Only rising edges are acted on; a Done held high counts once.
- Per-cycle combinational checks:
  - all_valid = &(Cipher_text_T ^ Cipher_text_F).
  - any_bad = |(Cipher_text_T & Cipher_text_F).
  - An all-zero spacer is neither valid nor bad.
- IDLE:
  - done_rise -> ARMED; timer cleared.
  - Out_Valid=0.
- ARMED:
  - any_bad -> FAULT with code 2. This takes priority over all_valid in the same cycle.
  - Else all_valid -> capture Cipher_text_T into cap_reg and go to STREAM, idx=0. Minimum latency is 1 cycle after done_rise.
  - Else timer++. When timer reaches TIMEOUT_CYC-1 with no valid codeword -> FAULT with code 1.
- STREAM:
  - Out_Valid=1. Out_Data = cap_reg word idx, most-significant word first (idx0=[127:96] ... idx3=[31:0]).
  - Out_Data and Out_Valid are registered and stable while Out_Ready=0. Wait time is unbounded.
  - On Out_Valid & Out_Ready: idx++. Out_Last=1 exactly when idx==3.
  - Handshake at idx==3 -> IDLE. Out_Valid drops the next cycle; back-to-back words are allowed every cycle.
  - done_rise during STREAM -> FAULT with code 3. The stream is aborted and Out_Valid drops the next cycle.
- FAULT:
  - Fault=1 and Fault_Code are held; Out_Valid=0; Busy=1.
  - Fault_Clr -> IDLE with Fault and Fault_Code cleared.
  - done_rise while in FAULT is ignored.
- Fault_Clr outside FAULT has no effect.
- cap_reg holds its value after IDLE; it is not cleared except by reset.

Optional Feature:
- Macro: AES_DR_FAULT_CHECK_EN.
- Defined: ARMED behaves exactly as described above, with codeword validity checks, timeout and the (1,1) fault.
- Undefined:
  - The F rail is ignored and Cipher_text_F is left unconnected internally.
  - ARMED counts CAPTURE_DLY cycles after done_rise, then captures Cipher_text_T and enters STREAM.
  - Fault_Code values 1 and 2 never occur. Overrun (code 3) remains.

Decomposition:
- Shared package aes_dr_pkg:
  - state enum {IDLE, ARMED, STREAM, FAULT}.
  - Fault_Code constants FC_NONE, FC_TIMEOUT, FC_BADPAIR, FC_OVERRUN.
  - N and W defaults.
- One natural sub-module, dr_codeword_check: purely combinational reduction of the two rails to all_valid/any_bad, reusable by other dual-rail stages.

Test Plan:
- Nominal, feature on: Done rises, 2 cycles of all-zero spacer, then T=128'h00112233_44556677_8899AABB_CCDDEEFF with F=~T, Out_Ready=1 -> words 00112233, 44556677, 8899AABB, CCDDEEFF on consecutive cycles; Out_Last on the 4th word only; back to IDLE.
- Backpressure: same data with Out_Ready=0 for 5 cycles, then toggling -> Out_Data stable while stalled, no word lost or duplicated, exactly 4 handshakes.
- Bad pair: in ARMED, T=F=all-ones on bit 5 only, other bits valid -> Fault=1, Fault_Code=2, Out_Valid stays 0; Fault_Clr pulse -> IDLE with Fault=0.
- Timeout, TIMEOUT_CYC=16: Done rises, rails held all-zero -> Fault_Code=1 exactly 16 cycles after done_rise.
- Overrun and reset: second Done rise during word 2 -> Fault_Code=3. Separately, Reset=0 mid-STREAM -> all outputs 0 immediately; next Done starts fresh at word 0.
- Feature off, CAPTURE_DLY=2: Done rises, F driven with garbage -> T captured 2 cycles after done_rise and streamed; no fault raised.

Source files
------------

// File: rtl/aes_dr_pkg.sv
// aes_dr_pkg: shared types and defaults for the dual-rail AES output stages
package aes_dr_pkg;
  localparam int DR_N = 128;
  localparam int DR_W = 32;
  typedef enum logic [1:0] {IDLE, ARMED, STREAM, FAULT} state_e;
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_BADPAIR = 2'd2;
  localparam logic [1:0] FC_OVERRUN = 2'd3;
endpackage

// File: rtl/dr_codeword_check.sv
// dr_codeword_check: reduces a dual-rail word to all-bits-valid and any-(1,1)-pair flags
module dr_codeword_check #(
  parameter int N = aes_dr_pkg::DR_N
) (
  input  logic [N-1:0] t_i,
  input  logic [N-1:0] f_i,
  output logic         all_valid_o,
  output logic         any_bad_o
);
  assign all_valid_o = &(t_i ^ f_i);
  assign any_bad_o   = |(t_i & f_i);
endmodule

// File: rtl/aes_dr_cipher_collector.sv
// aes_dr_cipher_collector: captures dual-rail ciphertext and streams it as W-bit words.
// AES_DR_FAULT_CHECK_EN enables codeword checks/timeout; otherwise capture after a fixed delay.
module aes_dr_cipher_collector
  import aes_dr_pkg::*;
#(
  parameter int N           = DR_N,
  parameter int W           = DR_W,
  parameter int TIMEOUT_CYC = 16,
  parameter int CAPTURE_DLY = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] Cipher_text_T,
  input  logic [N-1:0] Cipher_text_F,
  input  logic         Done,
  output logic [W-1:0] Out_Data,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic         Out_Last,
  output logic         Busy,
  output logic         Fault,
  output logic [1:0]   Fault_Code,
  input  logic         Fault_Clr
);
  localparam int NW = N / W;
  localparam int IW = $clog2(NW);
  localparam int TW = $clog2((TIMEOUT_CYC > CAPTURE_DLY ? TIMEOUT_CYC : CAPTURE_DLY) + 1);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  state_e                  state_q, state_d;
  logic                    done_d_q;
  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NW-1:0][W-1:0]    cap_q, cap_d;
  logic [1:0]              code_q, code_d;
  logic                    done_rise;

  assign done_rise = Done & ~done_d_q;

`ifdef AES_DR_FAULT_CHECK_EN
  logic all_valid, any_bad;
  dr_codeword_check #(.N(N)) u_chk (
    .t_i        (Cipher_text_T),
    .f_i        (Cipher_text_F),
    .all_valid_o(all_valid),
    .any_bad_o  (any_bad)
  );
`else
  logic unused_f;
  assign unused_f = ^Cipher_text_F;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      done_d_q <= 1'b0;
      timer_q  <= '0;
      idx_q    <= '0;
      cap_q    <= '0;
      code_q   <= FC_NONE;
    end else begin
      state_q  <= state_d;
      done_d_q <= Done;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: if (done_rise) begin
        state_d = ARMED;
        timer_d = '0;
      end
`ifdef AES_DR_FAULT_CHECK_EN
      ARMED: if (any_bad) begin
        state_d = FAULT;
        code_d  = FC_BADPAIR;
      end else if (all_valid) begin
        state_d = STREAM;
        cap_d   = Cipher_text_T;
        idx_d   = '0;
      end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = FAULT;
        code_d  = FC_TIMEOUT;
      end else begin
        timer_d = timer_q + TW'(1);
      end
`else
      ARMED: if (timer_q == TW'(CAPTURE_DLY - 1)) begin
        state_d = STREAM;
        cap_d   = Cipher_text_T;
        idx_d   = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
`endif
      // a fresh Done while words are still owed to the host aborts the stream
      STREAM: if (done_rise) begin
        state_d = FAULT;
        code_d  = FC_OVERRUN;
      end else if (Out_Ready) begin
        idx_d   = idx_q + IW'(1);
        state_d = (idx_q == LAST) ? IDLE : STREAM;
      end
      FAULT: if (Fault_Clr) begin
        state_d = IDLE;
        code_d  = FC_NONE;
      end
    endcase
  end

  always_comb begin
    Out_Valid  = (state_q == STREAM);
    Out_Data   = Out_Valid ? cap_q[LAST - idx_q] : '0;
    Out_Last   = Out_Valid & (idx_q == LAST);
    Busy       = (state_q != IDLE);
    Fault      = (state_q == FAULT);
    Fault_Code = code_q;
  end
endmodule

// File: tb/tb_aes_dr_cipher_collector.sv
// tb_aes_dr_cipher_collector: scoreboard bench for the ciphertext collector in either build
module tb_aes_dr_cipher_collector;
  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic [127:0] t = '0, f = '0;
  logic         Done = 1'b0;
  logic [31:0]  Out_Data;
  logic         Out_Valid, Out_Ready = 1'b0, Out_Last, Busy, Fault;
  logic [1:0]   Fault_Code;
  logic         Fault_Clr = 1'b0;

  int n_vec = 0, n_err = 0, hs = 0, hs0;
  logic [32:0] sb[$];
  logic [32:0] e;
  logic [127:0] d1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic [127:0] d2 = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  logic [127:0] d3 = 128'h11111111_22222222_33333333_44444444;
  logic [127:0] d4 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  logic [127:0] d5 = 128'h13579BDF_2468ACE0_CAFEBABE_0BADF00D;
  logic [127:0] v;

  aes_dr_cipher_collector dut (
    .Clk(Clk), .Reset(Reset), .Cipher_text_T(t), .Cipher_text_F(f), .Done(Done),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Last(Out_Last),
    .Busy(Busy), .Fault(Fault), .Fault_Code(Fault_Code), .Fault_Clr(Fault_Clr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_words(input logic [127:0] d);
    for (int i = 3; i >= 0; i--) sb.push_back({i == 0, d[i*32 +: 32]});
  endtask

  // leaves Done high and the DUT in STREAM on word 0
  task automatic load(input logic [127:0] d);
    Done = 1'b0;
    tick();
    Done = 1'b1;
    tick();
`ifdef AES_DR_FAULT_CHECK_EN
    t = '0;
    f = '0;
    tick();
    tick();
    chk("spacer_no_valid", Out_Valid, 1'b0);
    t = d;
    f = ~d;
    push_words(d);
    tick();
    chk("capture_valid", Out_Valid, 1'b1);
    t = '0;
    f = '0;
`else
    t = d;
    f = {$urandom, $urandom, $urandom, $urandom};
    tick();
    chk("delay_no_valid", Out_Valid, 1'b0);
    push_words(d);
    tick();
    chk("capture_valid", Out_Valid, 1'b1);
    t = '0;
    f = {$urandom, $urandom, $urandom, $urandom};
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (Busy || sb.size() != 0); i++) tick();
    chk("drain_queue", sb.size(), 0);
    chk("drain_idle", Busy, 1'b0);
  endtask

  always @(negedge Clk) begin
    if (Reset && Out_Valid && Out_Ready) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("word", Out_Data, e[31:0]);
        chk("last", Out_Last, e[32]);
        hs++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_valid", Out_Valid, 1'b0);
    chk("rst_data", Out_Data, 32'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_fault", {Fault, Fault_Code}, 3'b0);
    tick();
    Reset = 1'b1;
    tick();

    // nominal, Done held high through the stream counts once
    Out_Ready = 1'b1;
    load(d1);
    drain();
    chk("no_fault_held_done", Fault, 1'b0);
    Done = 1'b0;

    // backpressure
    Out_Ready = 1'b0;
    hs0 = hs;
    load(d2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", Out_Valid, 1'b1);
      chk("stall_data", Out_Data, d2[127:96]);
    end
    for (int i = 0; i < 40 && Busy; i++) begin
      Out_Ready = i[0];
      tick();
    end
    drain();
    chk("hs_count", hs - hs0, 4);
    Done = 1'b0;

`ifdef AES_DR_FAULT_CHECK_EN
    // bad pair on bit 5
    tick();
    Done = 1'b1;
    tick();
    v = d3;
    t = v;
    f = ~v;
    t[5] = 1'b1;
    f[5] = 1'b1;
    tick();
    chk("bad_fault", Fault, 1'b1);
    chk("bad_code", Fault_Code, 2'd2);
    chk("bad_valid", Out_Valid, 1'b0);
    Done = 1'b0;
    t = '0;
    f = '0;
    tick();
    Done = 1'b1;
    tick();
    chk("fault_ignores_done", Fault_Code, 2'd2);
    Fault_Clr = 1'b1;
    tick();
    Fault_Clr = 1'b0;
    chk("clr_fault", {Fault, Fault_Code}, 3'b0);
    chk("clr_busy", Busy, 1'b0);

    // timeout: rails stay at spacer
    Done = 1'b0;
    tick();
    Done = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", Fault, 1'b0);
    tick();
    chk("to_fault", Fault, 1'b1);
    chk("to_code", Fault_Code, 2'd1);
    Fault_Clr = 1'b1;
    tick();
    Fault_Clr = 1'b0;
    chk("to_clr", Busy, 1'b0);
    Done = 1'b0;
`endif

    // overrun: second Done rise while word 2 is presented
    Out_Ready = 1'b1;
    load(d3);
    Done = 1'b0;
    tick();
    Out_Ready = 1'b0;
    Done = 1'b1;
    tick();
    chk("ovr_code", Fault_Code, 2'd3);
    chk("ovr_fault", Fault, 1'b1);
    chk("ovr_valid", Out_Valid, 1'b0);
    chk("ovr_left", sb.size(), 3);
    sb.delete();
    Fault_Clr = 1'b1;
    tick();
    Fault_Clr = 1'b0;
    chk("ovr_clr", {Busy, Fault, Fault_Code}, 4'b0);
    Done = 1'b0;

    // asynchronous reset mid-stream
    load(d4);
    Done = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_valid", Out_Valid, 1'b0);
    chk("arst_data", Out_Data, 32'h0);
    chk("arst_busy", Busy, 1'b0);
    sb.delete();
    tick();
    Reset = 1'b1;
    tick();
    Out_Ready = 1'b1;
    load(d5);
    drain();
    chk("end_fault", Fault, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
